// File: rtl/bf_pkg.sv
// Shared opcode, ASCII and FSM definitions for the TinyBF program loader.
package bf_pkg;

  localparam logic [3:0] OP_HALT = 4'd0;
  localparam logic [3:0] OP_INCP = 4'd1;
  localparam logic [3:0] OP_DECP = 4'd2;
  localparam logic [3:0] OP_INC  = 4'd3;
  localparam logic [3:0] OP_DEC  = 4'd4;
  localparam logic [3:0] OP_OUT  = 4'd5;
  localparam logic [3:0] OP_IN   = 4'd6;
  localparam logic [3:0] OP_JMPF = 4'd7;
  localparam logic [3:0] OP_JMPB = 4'd8;

  localparam logic [7:0] ASCII_GT    = 8'h3E;
  localparam logic [7:0] ASCII_LT    = 8'h3C;
  localparam logic [7:0] ASCII_PLUS  = 8'h2B;
  localparam logic [7:0] ASCII_MINUS = 8'h2D;
  localparam logic [7:0] ASCII_DOT   = 8'h2E;
  localparam logic [7:0] ASCII_COMMA = 8'h2C;
  localparam logic [7:0] ASCII_LBRK  = 8'h5B;
  localparam logic [7:0] ASCII_RBRK  = 8'h5D;
  localparam logic [7:0] ASCII_TERM  = 8'h21;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARM   = 3'd1,
    ST_RECV  = 3'd2,
    ST_WRITE = 3'd3,
    ST_FILL  = 3'd4,
    ST_DONE  = 3'd5
  } prog_state_e;

endpackage

// File: rtl/bf_char_decode.sv
// Maps one received ASCII byte to a TinyBF opcode; flags commands and the terminator.
module bf_char_decode
  import bf_pkg::*;
(
  input  logic [7:0] rx_data_i,
  output logic       is_cmd_o,
  output logic       is_term_o,
  output logic [3:0] opcode_o
);

  always_comb begin
    is_cmd_o  = 1'b1;
    is_term_o = 1'b0;
    opcode_o  = OP_HALT;
    case (rx_data_i)
      ASCII_GT:    opcode_o = OP_INCP;
      ASCII_LT:    opcode_o = OP_DECP;
      ASCII_PLUS:  opcode_o = OP_INC;
      ASCII_MINUS: opcode_o = OP_DEC;
      ASCII_DOT:   opcode_o = OP_OUT;
      ASCII_COMMA: opcode_o = OP_IN;
      ASCII_LBRK:  opcode_o = OP_JMPF;
      ASCII_RBRK:  opcode_o = OP_JMPB;
      ASCII_TERM: begin
        is_cmd_o  = 1'b0;
        is_term_o = 1'b1;
      end
      default:     is_cmd_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/bf_prog_ctrl.sv
// Programming-mode controller: loads decoded opcodes into program memory,
// pads the tail with HALT and shares the memory port with the CPU fetch path.
module bf_prog_ctrl
  import bf_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int OP_W   = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              prog_mode_i,
  input  logic              cpu_busy_i,
  input  logic [7:0]        rx_data_i,
  input  logic              rx_valid_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_we_o,
  output logic [OP_W-1:0]   mem_wdata_o,
  output logic              cpu_hold_o,
  output logic              prog_busy_o,
  output logic              done_o,
  output logic              overrun_o,
  output logic [ADDR_W:0]   prog_len_o
);

  localparam logic [ADDR_W-1:0] ADDR_ONE  = 1;
  localparam logic [ADDR_W-1:0] ADDR_LAST = {ADDR_W{1'b1}};
  localparam logic [ADDR_W:0]   LEN_ONE   = 1;

  prog_state_e       state_q, state_d;
  logic              mode_q;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic              ovr_q, ovr_d;
  logic [OP_W-1:0]   op_q, op_d;

  logic       dec_cmd, dec_term;
  logic [3:0] dec_op;
  logic       mode_rise;

  bf_char_decode u_decode (
    .rx_data_i (rx_data_i),
    .is_cmd_o  (dec_cmd),
    .is_term_o (dec_term),
    .opcode_o  (dec_op)
  );

  assign mode_rise = prog_mode_i & ~mode_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= ST_IDLE;
      mode_q  <= 1'b0;
      addr_q  <= '0;
      len_q   <= '0;
      ovr_q   <= 1'b0;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= prog_mode_i;
      addr_q  <= addr_d;
      len_q   <= len_d;
      ovr_q   <= ovr_d;
      op_q    <= op_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    len_d       = len_q;
    ovr_d       = ovr_q;
    op_d        = op_q;
    mem_we_o    = 1'b0;
    mem_wdata_o = OP_W'(OP_HALT);
    done_o      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (mode_rise) begin
          state_d = ST_ARM;
          addr_d  = '0;
          len_d   = '0;
          ovr_d   = 1'b0;
        end
      end
      ST_ARM: begin
        if (!prog_mode_i)     state_d = ST_IDLE;
        else if (!cpu_busy_i) state_d = ST_RECV;
      end
      ST_RECV: begin
        if (rx_valid_i && dec_cmd) begin
          op_d    = OP_W'(dec_op);
          state_d = ST_WRITE;
        end else if ((rx_valid_i && dec_term) || !prog_mode_i) begin
          state_d = ST_FILL;
        end
      end
      ST_WRITE: begin
        mem_we_o    = 1'b1;
        mem_wdata_o = op_q;
        len_d       = len_q + LEN_ONE;
        // A full memory needs no HALT padding.
        if (addr_q == ADDR_LAST) begin
          state_d = ST_DONE;
        end else begin
          addr_d  = addr_q + ADDR_ONE;
          state_d = ST_RECV;
        end
      end
      ST_FILL: begin
        mem_we_o = 1'b1;
        if (addr_q == ADDR_LAST) state_d = ST_DONE;
        else                     addr_d  = addr_q + ADDR_ONE;
      end
      ST_DONE: begin
        done_o  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // No backpressure on the UART, so bytes arriving while busy writing are lost.
    if (rx_valid_i && (state_q == ST_WRITE || state_q == ST_FILL || state_q == ST_DONE))
      ovr_d = 1'b1;
  end

  assign prog_busy_o = (state_q != ST_IDLE);
  assign cpu_hold_o  = prog_busy_o;
  assign mem_addr_o  = prog_busy_o ? addr_q : cpu_addr_i;
  assign overrun_o   = ovr_q;
  assign prog_len_o  = len_q;

endmodule

// File: tb/tb_bf_prog_ctrl.sv
// Scoreboard bench for bf_prog_ctrl: expected memory writes are queued by the
// stimulus and consumed by a negedge monitor whenever mem_we_o is seen.
module tb_bf_prog_ctrl;
  localparam int AW = 5;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [3:0]    d;
  } wr_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          prog_mode = 1'b0;
  logic          cpu_busy = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_valid = 1'b0;
  logic [AW-1:0] cpu_addr = 5'd9;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [3:0]    mem_wdata;
  logic          cpu_hold, prog_busy, done, overrun;
  logic [AW:0]   prog_len;

  int  n_checks = 0;
  int  n_fail = 0;
  int  done_cnt = 0;
  wr_t exp_q[$];
  wr_t mon_e;

  bf_prog_ctrl #(.ADDR_W(AW), .OP_W(4)) dut (
    .clk_i(clk), .rst_i(rst_n), .prog_mode_i(prog_mode), .cpu_busy_i(cpu_busy),
    .rx_data_i(rx_data), .rx_valid_i(rx_valid), .cpu_addr_i(cpu_addr),
    .mem_addr_o(mem_addr), .mem_we_o(mem_we), .mem_wdata_o(mem_wdata),
    .cpu_hold_o(cpu_hold), .prog_busy_o(prog_busy), .done_o(done),
    .overrun_o(overrun), .prog_len_o(prog_len)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  always @(negedge clk) begin
    if (done === 1'b1) done_cnt++;
    if (mem_we === 1'b1) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write: addr %0d data %0d, no write expected", mem_addr, mem_wdata);
      end else begin
        mon_e = exp_q.pop_front();
        if ({mem_addr, mem_wdata} !== mon_e) begin
          n_fail++;
          $display("FAIL mem_write: got addr %0d data %0d, expected addr %0d data %0d",
                   mem_addr, mem_wdata, mon_e.a, mon_e.d);
        end else begin
          $display("write addr %0d data %0d ok", mem_addr, mem_wdata);
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end else begin
      $display("check %s = %0d ok", name, act);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    @(posedge clk); #1;
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send(s[i]);
  endtask

  task automatic push_w(input int a, input int d);
    exp_q.push_back(wr_t'({a[AW-1:0], d[3:0]}));
  endtask

  task automatic push_fill(input int from);
    for (int a = from; a < 32; a++) push_w(a, 0);
  endtask

  // Raise prog_mode with cpu_busy low: IDLE -> ARM -> RECV in two edges.
  task automatic start_session();
    @(posedge clk); #1;
    prog_mode = 1'b1;
    tick(2);
  endtask

  task automatic wait_done(input string name, input int start_cnt);
    int k = 0;
    while (done_cnt == start_cnt && k < 300) begin
      @(posedge clk);
      k++;
    end
    tick(3);
    chk(name, done_cnt - start_cnt, 1);
  endtask

  initial begin
    int dc;
    int bad;
    int k;

    #1;
    chk("rst_mem_addr", mem_addr, 9);
    chk("rst_we", mem_we, 0);
    chk("rst_busy", prog_busy, 0);
    chk("rst_hold", cpu_hold, 0);
    chk("rst_done", done, 0);
    chk("rst_len", prog_len, 0);
    chk("rst_overrun", overrun, 0);
    tick(2);
    rst_n = 1'b1;
    tick(2);

    // "+[-]!" program
    dc = done_cnt;
    start_session();
    chk("s1_hold", cpu_hold, 1);
    chk("s1_busy", prog_busy, 1);
    chk("s1_mem_addr_prog", mem_addr, 0);
    push_w(0, 3); push_w(1, 7); push_w(2, 4); push_w(3, 8); push_fill(4);
    send_str("+[-]!");
    wait_done("s1_done_pulses", dc);
    chk("s1_len", prog_len, 4);
    chk("s1_mem_addr_cpu", mem_addr, 9);
    chk("s1_busy_after", prog_busy, 0);
    chk("s1_pending", exp_q.size(), 0);
    chk("s1_overrun", overrun, 0);
    tick(5);
    chk("s1_no_restart", prog_busy, 0);
    prog_mode = 1'b0;
    tick(2);

    // CPU busy for 20 cycles after the request
    cpu_busy = 1'b1;
    dc = done_cnt;
    @(posedge clk); #1;
    prog_mode = 1'b1;
    tick(1);
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (cpu_hold !== 1'b1 || mem_we !== 1'b0) bad++;
    end
    chk("s2_hold_while_busy", bad, 0);
    #1;
    cpu_busy = 1'b0;
    push_w(0, 3); push_fill(1);
    tick(2);
    send_str("+!");
    wait_done("s2_done_pulses", dc);
    chk("s2_len", prog_len, 1);
    chk("s2_pending", exp_q.size(), 0);
    prog_mode = 1'b0;
    tick(2);

    // 40 '>' bytes: memory fills at 32, no HALT padding
    dc = done_cnt;
    start_session();
    for (int a = 0; a < 32; a++) push_w(a, 1);
    for (int i = 0; i < 40; i++) send(8'h3E);
    wait_done("s3_done_pulses", dc);
    chk("s3_len", prog_len, 32);
    chk("s3_pending", exp_q.size(), 0);
    prog_mode = 1'b0;
    tick(2);

    // Ignored characters, session ended by prog_mode falling
    dc = done_cnt;
    start_session();
    chk("s4_overrun_cleared", overrun, 0);
    push_w(0, 3); push_w(1, 4); push_fill(2);
    send_str("a+b\n-");
    prog_mode = 1'b0;
    wait_done("s4_done_pulses", dc);
    chk("s4_len", prog_len, 2);
    chk("s4_pending", exp_q.size(), 0);
    tick(2);

    // Back-to-back "++": second byte lands in WRITE
    dc = done_cnt;
    start_session();
    push_w(0, 3); push_fill(1);
    @(posedge clk); #1;
    rx_data  = 8'h2B;
    rx_valid = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    chk("s5_overrun_set", overrun, 1);
    send(8'h21);
    wait_done("s5_done_pulses", dc);
    chk("s5_overrun_sticky", overrun, 1);
    chk("s5_len", prog_len, 1);
    chk("s5_pending", exp_q.size(), 0);
    prog_mode = 1'b0;
    tick(2);

    // Asynchronous reset during FILL at address 10
    start_session();
    chk("s6_overrun_cleared", overrun, 0);
    push_fill(0);
    send(8'h21);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!(mem_we === 1'b1 && mem_addr == 5'd10) && k < 100);
    chk("s6_reached_addr10", (k < 100) ? 1 : 0, 1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("s6_rst_we", mem_we, 0);
    chk("s6_rst_busy", prog_busy, 0);
    chk("s6_rst_hold", cpu_hold, 0);
    chk("s6_rst_done", done, 0);
    chk("s6_rst_len", prog_len, 0);
    chk("s6_rst_mem_addr", mem_addr, 9);
    chk("s6_unwritten", exp_q.size(), 21);
    exp_q.delete();
    prog_mode = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(3);
    chk("s6_idle_busy", prog_busy, 0);
    cpu_addr = 5'd17;
    #1;
    chk("s6_mem_addr_follow", mem_addr, 17);
    tick(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
